// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
//
// Shares the core's single memory port between instruction fetch (I) and the
// M-stage data requester (D). Only one transaction is outstanding at a time.
// Data has priority. A starvation counter makes sure fetch is granted after at
// most STARVE_LIMIT data grants taken while fetch was waiting. A fetch flush
// discards the in-flight fetch response but still lets the bus transaction
// complete.
//
// Ports
//   clk, rst_n          : core clock, synchronous active-low reset
//   i_req_* / i_rsp_*   : fetch request (valid/ready/addr) and response pulse
//   i_flush             : drop the in-flight fetch response; block a fetch grant
//   d_req_* / d_rsp_*   : data request (load/store) and response pulse
//   mem_req_*           : registered bus request, held until mem_req_ready
//   mem_rsp_*           : bus response, one per accepted request
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no transaction; grants are issued here only
// REQ   | mem_req_valid high, waiting for mem_req_ready
// WAIT  | request accepted, waiting for mem_rsp_valid
module core_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_flush,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_wen,
    input  logic [31:0] d_req_wdata,
    input  logic [3:0]  d_req_wstrb,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner_i;
    logic          drop;
    logic [CW-1:0] starve_cnt;
    logic          fetch_elig;
    logic          grant_d;
    logic          grant_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        fetch_elig = i_req_valid && !i_flush;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        state_nxt  = state;
        case (state)
            IDLE: begin
                // Data wins unless fetch has waited through LIMIT data grants.
                grant_d = d_req_valid && !((starve_cnt == LIMIT) && fetch_elig);
                grant_i = fetch_elig && !grant_d;
                if (grant_d || grant_i) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign i_req_ready   = grant_i;
    assign d_req_ready   = grant_d;
    assign mem_req_valid = (state == REQ);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_i       <= 1'b0;
            drop          <= 1'b0;
            starve_cnt    <= '0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            i_rsp_valid   <= 1'b0;
            i_rsp_data    <= '0;
            d_rsp_valid   <= 1'b0;
            d_rsp_rdata   <= '0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;

            if (grant_d) begin
                owner_i       <= 1'b0;
                mem_req_addr  <= d_req_addr;
                mem_req_wen   <= d_req_wen;
                mem_req_wdata <= d_req_wdata;
                mem_req_wstrb <= d_req_wstrb;
                if (fetch_elig && (starve_cnt != LIMIT)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (grant_i) begin
                owner_i       <= 1'b1;
                mem_req_addr  <= i_req_addr;
                mem_req_wen   <= 1'b0;
                mem_req_wdata <= '0;
                mem_req_wstrb <= '0;
                starve_cnt    <= '0;
            end

            if ((state == REQ || state == WAIT) && owner_i && i_flush) begin
                drop <= 1'b1;
            end

            if (state == WAIT && mem_rsp_valid) begin
                // Leaving for IDLE: clearing drop here overrides the set above.
                drop <= 1'b0;
                if (owner_i) begin
                    // A flush arriving together with the response still drops it.
                    if (!(drop || i_flush)) begin
                        i_rsp_valid <= 1'b1;
                        i_rsp_data  <= mem_rsp_rdata;
                    end
                end else begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_rdata <= mem_req_wen ? 32'd0 : mem_rsp_rdata;
                end
            end
        end
    end

endmodule
